// File: rtl/move_scheduler.sv
// Move pacing and direction sequencing between keyboard_driver and the snake engine.
// Keys become queued directions; one move request is issued per period over req/ack.
module move_scheduler #(
  parameter int SLOW_PERIOD = 25_000_000,
  parameter int FAST_PERIOD = 6_250_000,
  parameter int TURBO_MOVES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key,
  input  logic       turbo_button,
  input  logic       enable,
  input  logic       move_ack,
  output logic       move_req,
  output logic [2:0] dir,
  output logic       turbo_active
);

  localparam int MAX_P = (SLOW_PERIOD > FAST_PERIOD) ? SLOW_PERIOD : FAST_PERIOD;
  localparam int CW    = $clog2(MAX_P) + 1;

  typedef enum logic [1:0] {IDLE, COUNT, REQ} state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [2:0]      q_reg [0:1];
  logic [2:0]      q_next [0:1];
  logic [1:0]      q_count_reg, q_count_next;
  logic [2:0]      dir_reg, dir_next;
  logic            move_req_reg;
  logic [7:0]      turbo_cnt_reg;
  logic            turbo_active_reg;
  logic [7:0]      key_prev_reg;
  logic            turbo_prev_reg;

  logic            key_valid;
  logic [2:0]      key_dir;
  logic [CW-1:0]   period_m1;
  logic            fire, pop, accept, push, turbo_rise;
  logic [1:0]      count_a;
  logic [2:0]      a0, a1, tail;

  // Numpad layout: 6 is right, then counter-clockwise around the keypad.
  always_comb begin
    key_valid = 1'b1;
    key_dir   = 3'd0;
    case (key)
      8'h36: key_dir = 3'd0;
      8'h39: key_dir = 3'd1;
      8'h38: key_dir = 3'd2;
      8'h37: key_dir = 3'd3;
      8'h34: key_dir = 3'd4;
      8'h31: key_dir = 3'd5;
      8'h32: key_dir = 3'd6;
      8'h33: key_dir = 3'd7;
      default: key_valid = 1'b0;
    endcase
  end

  assign period_m1  = (turbo_cnt_reg != 8'd0) ? CW'(FAST_PERIOD - 1) : CW'(SLOW_PERIOD - 1);
  assign fire       = (state_reg == COUNT) && enable && (cnt_reg == period_m1);
  assign pop        = fire && (q_count_reg != 2'd0);
  assign accept     = (state_reg == REQ) && enable && move_ack;
  assign turbo_rise = turbo_button && !turbo_prev_reg;

  // Pop is applied first; the push sees the post-pop queue and the post-pop dir.
  always_comb begin
    a0       = pop ? q_reg[1] : q_reg[0];
    a1       = q_reg[1];
    count_a  = q_count_reg - 2'(pop);
    dir_next = pop ? q_reg[0] : dir_reg;
    if (count_a == 2'd0)      tail = dir_next;
    else if (count_a == 2'd1) tail = a0;
    else                      tail = a1;
    push = enable && key_valid && (key != key_prev_reg) && (key_dir != tail) &&
           (key_dir != (tail ^ 3'd4)) && (count_a != 2'd2);
    q_next[0] = a0;
    q_next[1] = a1;
    if (push) begin
      if (count_a == 2'd0) q_next[0] = key_dir;
      else                 q_next[1] = key_dir;
    end
    q_count_next = enable ? (count_a + 2'(push)) : 2'd0;
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_queue
      always_ff @(posedge clk) begin
        if (rst) q_reg[gi] <= 3'd0;
        else     q_reg[gi] <= q_next[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      q_count_reg      <= 2'd0;
      dir_reg          <= 3'd4;
      move_req_reg     <= 1'b0;
      turbo_cnt_reg    <= 8'd0;
      turbo_active_reg <= 1'b0;
      key_prev_reg     <= 8'h34;
      turbo_prev_reg   <= 1'b0;
    end else begin
      q_count_reg      <= q_count_next;
      dir_reg          <= dir_next;
      key_prev_reg     <= key;
      turbo_prev_reg   <= turbo_button;
      turbo_active_reg <= (turbo_cnt_reg != 8'd0);
      if (turbo_rise)
        turbo_cnt_reg <= 8'(TURBO_MOVES);
      else if (accept && (turbo_cnt_reg != 8'd0))
        turbo_cnt_reg <= turbo_cnt_reg - 8'd1;

      if (!enable) begin
        state_reg    <= IDLE;
        cnt_reg      <= '0;
        move_req_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            state_reg <= COUNT;
            cnt_reg   <= '0;
          end
          COUNT: begin
            if (fire) begin
              state_reg    <= REQ;
              cnt_reg      <= '0;
              move_req_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
          REQ: begin
            if (move_ack) begin
              state_reg    <= COUNT;
              cnt_reg      <= '0;
              move_req_reg <= 1'b0;
            end
          end
          default: begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            move_req_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign move_req     = move_req_reg;
  assign dir          = dir_reg;
  assign turbo_active = turbo_active_reg;

endmodule

// File: tb/tb_move_scheduler.sv
// Self-checking bench for move_scheduler: queue-based reference model compared every
// cycle, plus hand-computed request spacings and directions.
module tb_move_scheduler;

  localparam int SLOW  = 8;
  localparam int FAST  = 3;
  localparam int TURBO = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] key = 8'h34;
  logic       turbo_button = 1'b0;
  logic       enable = 1'b0;
  logic       move_ack = 1'b1;
  logic       move_req;
  logic [2:0] dir;
  logic       turbo_active;

  move_scheduler #(.SLOW_PERIOD(SLOW), .FAST_PERIOD(FAST), .TURBO_MOVES(TURBO)) dut (
    .clk(clk), .rst(rst), .key(key), .turbo_button(turbo_button), .enable(enable),
    .move_ack(move_ack), .move_req(move_req), .dir(dir), .turbo_active(turbo_active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise = 0;
  int gaps[$];

  // Reference model state: phase 0 idle, 1 counting, 2 requesting.
  int  m_phase, m_elapsed, m_dir, m_tcnt;
  bit  m_req, m_active, m_tprev;
  logic [7:0] m_kprev;
  int  m_q[$];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic int key_to_dir(logic [7:0] k);
    case (k)
      8'h36: return 0;
      8'h39: return 1;
      8'h38: return 2;
      8'h37: return 3;
      8'h34: return 4;
      8'h31: return 5;
      8'h32: return 6;
      8'h33: return 7;
      default: return -1;
    endcase
  endfunction

  task automatic model_step();
    int kd, tail, per, old_cnt;
    bit accept, fire;
    if (rst) begin
      m_req = 0; m_dir = 4; m_active = 0; m_phase = 0; m_elapsed = 0;
      m_q.delete(); m_tcnt = 0; m_kprev = 8'h34; m_tprev = 0;
      return;
    end
    old_cnt = m_tcnt;
    per     = (m_tcnt != 0) ? FAST : SLOW;
    accept  = (m_phase == 2) && move_ack && enable;
    fire    = (m_phase == 1) && enable && (m_elapsed == per - 1);
    if (fire && m_q.size() > 0) m_dir = m_q.pop_front();
    kd = key_to_dir(key);
    if (enable && kd >= 0 && key != m_kprev) begin
      tail = (m_q.size() > 0) ? m_q[$] : m_dir;
      if (kd != tail && kd != (tail + 4) % 8 && m_q.size() < 2) m_q.push_back(kd);
    end
    if (!enable) m_q.delete();
    if (turbo_button && !m_tprev) m_tcnt = TURBO;
    else if (accept && m_tcnt > 0) m_tcnt--;
    m_active = (old_cnt != 0);
    if (!enable) begin
      m_phase = 0; m_elapsed = 0; m_req = 0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_elapsed = 0;
    end else if (m_phase == 1) begin
      if (fire) begin m_phase = 2; m_req = 1; end
      else m_elapsed++;
    end else if (accept) begin
      m_phase = 1; m_elapsed = 0; m_req = 0;
    end
    m_kprev = key;
    m_tprev = turbo_button;
  endtask

  // One clock: advance model with the applied inputs, then compare after the edge.
  task automatic tick();
    bit prev;
    prev = move_req;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk("move_req", int'(move_req), int'(m_req));
    chk("dir", int'(dir), m_dir);
    chk("turbo_active", int'(turbo_active), int'(m_active));
    if (!prev && move_req) begin
      gaps.push_back(cyc - last_rise);
      last_rise = cyc;
    end
  endtask

  task automatic wait_rise(output int n);
    bit p, rose;
    n = 0;
    rose = 0;
    while (!rose && n < 60) begin
      p = move_req;
      tick();
      n++;
      rose = !p && move_req;
    end
    if (!rose) chk("req_timeout", 0, 1);
  endtask

  task automatic chk_gaps(string name, int e0, int e1, int e2, int e3, int cnt);
    int exp[4];
    exp = '{e0, e1, e2, e3};
    chk({name, "_count"}, gaps.size(), cnt);
    for (int i = 0; i < cnt && i < gaps.size(); i++) chk({name, "_gap"}, gaps[i], exp[i]);
  endtask

  int n;

  initial begin
    // 1: reset values, free-running period of SLOW+1 with dir 4, reset mid-count
    repeat (3) tick();
    chk("reset_req", int'(move_req), 0);
    chk("reset_dir", int'(dir), 4);
    chk("reset_turbo", int'(turbo_active), 0);
    rst = 0; enable = 1; move_ack = 1;
    wait_rise(n); chk("first_req_latency", n, 9);
    wait_rise(n); chk("req_spacing", n, 9);
    chk("req_dir", int'(dir), 4);
    repeat (3) tick();
    rst = 1; tick();
    chk("midreset_req", int'(move_req), 0);
    chk("midreset_dir", int'(dir), 4);
    rst = 0;

    // 2: two queued keys, third dropped while full
    wait_rise(n);
    key = 8'h38; tick();
    key = 8'h36; tick();
    key = 8'h32; tick();
    wait_rise(n); chk("queued_dir0", int'(dir), 2);
    wait_rise(n); chk("queued_dir1", int'(dir), 0);
    wait_rise(n); chk("dropped_dir", int'(dir), 0);

    // 3: reach dir 4, then opposite and invalid keys are ignored
    key = 8'h38; tick();
    key = 8'h34; tick();
    wait_rise(n); chk("to_up", int'(dir), 2);
    wait_rise(n); chk("to_left", int'(dir), 4);
    key = 8'h36; tick();
    key = 8'h35; tick();
    key = 8'h41; tick();
    wait_rise(n); chk("opposite_ignored", int'(dir), 4);

    // 4a: 5-cycle press, reload coincides with an ack: two fast moves then slow
    gaps.delete();
    turbo_button = 1; repeat (5) tick();
    chk("turbo_on", int'(turbo_active), 1);
    turbo_button = 0;
    wait_rise(n);
    wait_rise(n);
    chk("turbo_off", int'(turbo_active), 0);
    chk_gaps("turbo_a", 4, 4, 9, 0, 3);

    // 4b: second press on the ack of the first fast move reloads to 2
    gaps.delete();
    turbo_button = 1; tick(); turbo_button = 0;
    wait_rise(n);
    turbo_button = 1; tick(); turbo_button = 0;
    wait_rise(n);
    wait_rise(n);
    wait_rise(n);
    chk_gaps("turbo_b", 4, 4, 4, 9, 4);

    // 5: request held while ack low
    move_ack = 0;
    repeat (20) tick();
    chk("hold_req", int'(move_req), 1);
    chk("hold_dir", int'(dir), 4);
    move_ack = 1; tick();
    chk("ack_drop", int'(move_req), 0);
    wait_rise(n); chk("after_ack", n, 8);

    // 6: disable during REQ with a full queue flushes it and withdraws the request
    move_ack = 0;
    key = 8'h38; tick();
    key = 8'h36; tick();
    enable = 0; tick();
    chk("withdraw", int'(move_req), 0);
    repeat (2) tick();
    enable = 1; move_ack = 1;
    wait_rise(n); chk("reenable_latency", n, 9);
    chk("flushed_dir", int'(dir), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
